// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - two-read/one-write register file with valid tracking, bypass and clear sweep
module register_file_mp #(
    parameter int                 WIDTH       = 8,
    parameter int                 DEPTH       = 8,
    parameter bit                 BYPASS      = 1'b1,
    parameter logic [WIDTH-1:0]   CLEAR_VALUE = '0,
    localparam int                AW          = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    a1,
    input  logic [AW-1:0]    a2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             valid1,
    output logic             valid2,
    input  logic             clr,
    output logic             busy
);

    // Addresses are compared one bit wider so that DEPTH itself is representable
    // when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic             sweeping;
    logic             wa_in_range;
    logic             a1_in_range;
    logic             a2_in_range;
    logic             wr_en;

    assign sweeping    = (state_q == SWEEP);
    assign wa_in_range = ({1'b0, wa} < DEPTH_W);
    assign a1_in_range = ({1'b0, a1} < DEPTH_W);
    assign a2_in_range = ({1'b0, a2} < DEPTH_W);

    // A write only lands while the clear engine is idle and the address exists.
    assign wr_en = we && !sweeping && wa_in_range;

    assign busy = sweeping;

    // Clear FSM state and sweep index registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Clear FSM next state: a clr in IDLE starts a sweep; the sweep ends after the last entry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Storage array: reset and sweep load CLEAR_VALUE, otherwise accept the write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= CLEAR_VALUE;
            end
            valid_q <= '0;
        end else if (sweeping) begin
            mem_q[idx_q]   <= CLEAR_VALUE;
            valid_q[idx_q] <= 1'b0;
        end else if (wr_en) begin
            mem_q[wa]   <= wd;
            valid_q[wa] <= 1'b1;
        end
    end

    // Read port 1: out-of-range reads return zero, bypass forwards the in-flight write.
    always_comb begin
        rd1    = '0;
        valid1 = 1'b0;
        if (a1_in_range) begin
            rd1    = mem_q[a1];
            valid1 = valid_q[a1];
            if (BYPASS && wr_en && (a1 == wa)) begin
                rd1    = wd;
                valid1 = 1'b1;
            end
        end
    end

    // Read port 2: identical to port 1 and fully independent of it.
    always_comb begin
        rd2    = '0;
        valid2 = 1'b0;
        if (a2_in_range) begin
            rd2    = mem_q[a2];
            valid2 = valid_q[a2];
            if (BYPASS && wr_en && (a2 == wa)) begin
                rd2    = wd;
                valid2 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - self-checking bench for register_file_mp (three parameterisations)
`timescale 1ns/100ps
module tb_register_file_mp;

    logic       clock;
    logic       reset;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] a1;
    logic [2:0] a2;
    logic       clr;

    // Instance 0: DEPTH 8 bypass on; 1: DEPTH 8 bypass off; 2: DEPTH 6 bypass on.
    logic [2:0][7:0] rd1_w;
    logic [2:0][7:0] rd2_w;
    logic [2:0]      valid1_w;
    logic [2:0]      valid2_w;
    logic [2:0]      busy_w;

    int checks   = 0;
    int failures = 0;

    register_file_mp #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1), .CLEAR_VALUE(8'h00)) u_dut_a (
        .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd), .a1(a1), .a2(a2),
        .rd1(rd1_w[0]), .rd2(rd2_w[0]), .valid1(valid1_w[0]), .valid2(valid2_w[0]),
        .clr(clr), .busy(busy_w[0])
    );

    register_file_mp #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b0), .CLEAR_VALUE(8'h00)) u_dut_b (
        .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd), .a1(a1), .a2(a2),
        .rd1(rd1_w[1]), .rd2(rd2_w[1]), .valid1(valid1_w[1]), .valid2(valid2_w[1]),
        .clr(clr), .busy(busy_w[1])
    );

    register_file_mp #(.WIDTH(8), .DEPTH(6), .BYPASS(1'b1), .CLEAR_VALUE(8'h00)) u_dut_c (
        .clock(clock), .reset(reset), .we(we), .wa(wa), .wd(wd), .a1(a1), .a2(a2),
        .rd1(rd1_w[2]), .rd2(rd2_w[2]), .valid1(valid1_w[2]), .valid2(valid2_w[2]),
        .clr(clr), .busy(busy_w[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: contents, written flags and cycles of clearing left per instance.
    int         depth_m [3] = '{8, 8, 6};
    bit         byp_m   [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] mm      [3][8];
    bit         mv      [3][8];
    int         left_m  [3];

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                for (int e = 0; e < 8; e++) begin
                    mm[k][e] = 8'h00;
                    mv[k][e] = 1'b0;
                end
                left_m[k] = 0;
            end else if (left_m[k] > 0) begin
                mm[k][depth_m[k] - left_m[k]] = 8'h00;
                mv[k][depth_m[k] - left_m[k]] = 1'b0;
                left_m[k] = left_m[k] - 1;
            end else begin
                if (we && int'(wa) < depth_m[k]) begin
                    mm[k][wa] = wd;
                    mv[k][wa] = 1'b1;
                end
                if (clr) left_m[k] = depth_m[k];
            end
        end
    end

    function automatic logic [8:0] exp_read(input int k, input logic [2:0] a);
        if (int'(a) >= depth_m[k]) return 9'h000;
        if (byp_m[k] && we && left_m[k] == 0 && int'(wa) < depth_m[k] && a == wa)
            return {1'b1, wd};
        return {mv[k][a], mm[k][a]};
    endfunction

    // Every cycle, every instance: outputs against the model.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            logic [8:0] e1;
            logic [8:0] e2;
            e1 = exp_read(k, a1);
            e2 = exp_read(k, a2);
            chk($sformatf("model_rd1[%0d]", k), int'(rd1_w[k]), int'(e1[7:0]));
            chk($sformatf("model_valid1[%0d]", k), int'(valid1_w[k]), int'(e1[8]));
            chk($sformatf("model_rd2[%0d]", k), int'(rd2_w[k]), int'(e2[7:0]));
            chk($sformatf("model_valid2[%0d]", k), int'(valid2_w[k]), int'(e2[8]));
            chk($sformatf("model_busy[%0d]", k), int'(busy_w[k]), int'(left_m[k] > 0));
        end
    end

    // Length of the most recently completed busy pulse per instance.
    int run_cnt  [3];
    int last_run [3];
    always @(negedge clock or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                run_cnt[k]  = 0;
                last_run[k] = 0;
            end else if (busy_w[k]) begin
                run_cnt[k] = run_cnt[k] + 1;
            end else if (run_cnt[k] != 0) begin
                last_run[k] = run_cnt[k];
                run_cnt[k]  = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input int addr, input int data);
        we = 1'b1;
        wa = 3'(addr);
        wd = 8'(data);
        cyc();
        we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_w[0] && n < 40) begin
            cyc();
            n++;
        end
        chk("busy_fall_timeout", int'(busy_w[0]), 0);
        cyc();
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; a1 = '0; a2 = '0; clr = 1'b0;
        cyc();
        cyc();
        chk("reset_rd1", int'(rd1_w[0]), 8'h00);
        chk("reset_valid1", int'(valid1_w[0]), 0);
        chk("reset_busy", int'(busy_w[0]), 0);
        reset = 1'b0;
        cyc();

        // Basic write then dual read of the same address.
        write(5, 8'hAA);
        a1 = 3'd5; a2 = 3'd5; #1;
        chk("t1_rd1", int'(rd1_w[0]), 8'hAA);
        chk("t1_rd2", int'(rd2_w[0]), 8'hAA);
        chk("t1_valid1", int'(valid1_w[0]), 1);
        chk("t1_valid2", int'(valid2_w[0]), 1);
        a1 = 3'd3; #1;
        chk("t1_unwritten_rd1", int'(rd1_w[0]), 8'h00);
        chk("t1_unwritten_valid1", int'(valid1_w[0]), 0);

        // Same-cycle bypass, on and off.
        a1 = 3'd2; we = 1'b1; wa = 3'd2; wd = 8'h3C; #1;
        chk("t2_bypass_rd1", int'(rd1_w[0]), 8'h3C);
        chk("t2_bypass_valid1", int'(valid1_w[0]), 1);
        chk("t2_nobypass_rd1", int'(rd1_w[1]), 8'h00);
        chk("t2_nobypass_valid1", int'(valid1_w[1]), 0);
        cyc();
        we = 1'b0; #1;
        chk("t2_nobypass_after_rd1", int'(rd1_w[1]), 8'h3C);
        chk("t2_nobypass_after_valid1", int'(valid1_w[1]), 1);

        // Fill, sweep, mid-sweep view, post-sweep contents.
        for (int i = 0; i < 8; i++) write(i, 8'h10 + i);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc(); cyc(); cyc();
        a1 = 3'd2; a2 = 3'd4; #1;
        chk("t3_mid_rd1", int'(rd1_w[0]), 8'h00);
        chk("t3_mid_valid1", int'(valid1_w[0]), 0);
        chk("t3_mid_rd2", int'(rd2_w[0]), 8'h14);
        chk("t3_mid_valid2", int'(valid2_w[0]), 1);
        wait_idle();
        chk("t3_busy_len_a", last_run[0], 8);
        chk("t3_busy_len_c", last_run[2], 6);
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(i); #1;
            chk($sformatf("t3_cleared_rd1[%0d]", i), int'(rd1_w[0]), 8'h00);
            chk($sformatf("t3_cleared_valid2[%0d]", i), int'(valid2_w[0]), 0);
        end

        // Writes and clr during a sweep are ignored.
        for (int i = 0; i < 8; i++) write(i, 8'h10 + i);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc(); cyc();
        a1 = 3'd7; we = 1'b1; wa = 3'd7; wd = 8'hFF; clr = 1'b1; #1;
        chk("t4_no_bypass_busy", int'(rd1_w[0]), 8'h17);
        cyc();
        we = 1'b0; clr = 1'b0;
        wait_idle();
        chk("t4_busy_len_a", last_run[0], 8);
        chk("t4_busy_len_c", last_run[2], 6);
        a1 = 3'd7; #1;
        chk("t4_mem7_rd1", int'(rd1_w[0]), 8'h00);
        chk("t4_mem7_valid1", int'(valid1_w[0]), 0);

        // Out-of-range write and read on the DEPTH=6 instance.
        write(6, 8'h55);
        a1 = 3'd6; a2 = 3'd0; #1;
        chk("t5_oor_rd1", int'(rd1_w[2]), 8'h00);
        chk("t5_oor_valid1", int'(valid1_w[2]), 0);
        chk("t5_inrange_a_rd1", int'(rd1_w[0]), 8'h55);

        // Reset in the middle of a sweep.
        for (int i = 0; i < 8; i++) write(i, 8'h10 + i);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc(); cyc();
        a1 = 3'd5; a2 = 3'd7; #1;
        chk("t6_pre_rd1", int'(rd1_w[0]), 8'h15);
        chk("t6_pre_busy", int'(busy_w[0]), 1);
        reset = 1'b1; #1;
        chk("t6_async_busy", int'(busy_w[0]), 0);
        chk("t6_async_rd1", int'(rd1_w[0]), 8'h00);
        chk("t6_async_rd2", int'(rd2_w[0]), 8'h00);
        chk("t6_async_valid2", int'(valid2_w[0]), 0);
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(7 - i); #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("t6_rd1[%0d][%0d]", k, i), int'(rd1_w[k]), 8'h00);
                chk($sformatf("t6_valid1[%0d][%0d]", k, i), int'(valid1_w[k]), 0);
            end
        end
        reset = 1'b0;
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
